// File: rtl/cpu19_pkg.sv
// cpu19_pkg
// Shared constants for the 19-bit CPU execute stage:
//   - datapath / register-index / immediate widths
//   - ALU opcode encodings
//   - multiply FSM state encoding
//   - MEM-stage control bundle and immediate sign-extension helper
package cpu19_pkg;

  localparam int DATA_W    = 19;
  localparam int REG_AW    = 3;
  localparam int IMM_W     = 8;
  localparam int MUL_STEPS = DATA_W;  // one multiplier bit per cycle

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00101;
  localparam logic [4:0] OP_XOR = 5'b00110;
  localparam logic [4:0] OP_NOT = 5'b00111;
  localparam logic [4:0] OP_SLL = 5'b01000;
  localparam logic [4:0] OP_SRL = 5'b01001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Control bits carried unchanged from EX into MEM.
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
  } mem_ctrl_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/ex_stage_mul_iter19.sv
// mul_iter19
// Iterative shift-add multiplier, one multiplier bit per cycle, result
// modulo 2^DATA_W.  Owns the IDLE -> BUSY -> DONE sequencing.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   i_start     load operands and begin (honoured in IDLE only)
//   i_abort     return to IDLE immediately (branch flush)
//   i_a, i_b    multiplicand, multiplier
//   o_busy      high while partial products are accumulating
//   o_done      high for the single cycle the product is valid
//   o_product   low DATA_W bits of i_a * i_b
module mul_iter19
  import cpu19_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);

  logic [1:0]        r_state;
  logic [4:0]        r_count;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_abort) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Multiplicand shifts left instead of indexing the partial
          // product; bits past DATA_W fall off, giving the modulo result.
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 5'd1;
          if (r_count == 5'(MUL_STEPS - 1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state == ST_BUSY);
  assign o_done    = (r_state == ST_DONE);
  assign o_product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// ex_stage
// Execute stage of the 19-bit pipelined CPU: operand forwarding from
// MEM/WB, single-cycle ALU, iterative multiply with upstream stall, and
// the EX/MEM pipeline register.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   EX_*                              ID/EX pipeline register outputs
//   WB_regwrite, WB_wreg, WB_wdata    WB-stage write-back (forward source)
//   ex_flush                          kill the instruction in EX
//   ex_stall                          hold IF/ID and ID/EX
//   MEM_*                             EX/MEM pipeline register outputs
module ex_stage
  import cpu19_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        EX_opcode,
  input  logic              EX_regwrite,
  input  logic              EX_memtoreg,
  input  logic              EX_memread,
  input  logic              EX_memwrite,
  input  logic              EX_alusrc,
  input  logic              EX_aluop,
  input  logic              EX_regdist,
  input  logic [IMM_W-1:0]  EX_immediate,
  input  logic [REG_AW-1:0] EX_rs,
  input  logic [REG_AW-1:0] EX_rt,
  input  logic [REG_AW-1:0] EX_rd,
  input  logic [DATA_W-1:0] EX_rd1,
  input  logic [DATA_W-1:0] EX_rd2,
  input  logic              WB_regwrite,
  input  logic [REG_AW-1:0] WB_wreg,
  input  logic [DATA_W-1:0] WB_wdata,
  input  logic              ex_flush,
  output logic              ex_stall,
  output logic              MEM_regwrite,
  output logic              MEM_memtoreg,
  output logic              MEM_memread,
  output logic              MEM_memwrite,
  output logic [DATA_W-1:0] MEM_alu_result,
  output logic [DATA_W-1:0] MEM_store_data,
  output logic [REG_AW-1:0] MEM_wreg,
  output logic              MEM_zero
);

  // Forwarding: index 0 is the rs path (rd1), index 1 the rt path (rd2).
  // A MEM-stage load is never a source; its data does not exist yet.
  logic [REG_AW-1:0] w_src_idx [2];
  logic [DATA_W-1:0] w_src_rf  [2];
  logic [DATA_W-1:0] w_fwd     [2];

  assign w_src_idx[0] = EX_rs;
  assign w_src_idx[1] = EX_rt;
  assign w_src_rf[0]  = EX_rd1;
  assign w_src_rf[1]  = EX_rd2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        w_fwd[gi] = w_src_rf[gi];
        if (MEM_regwrite && !MEM_memtoreg && (MEM_wreg == w_src_idx[gi])) begin
          w_fwd[gi] = MEM_alu_result;
        end else if (WB_regwrite && (WB_wreg == w_src_idx[gi])) begin
          w_fwd[gi] = WB_wdata;
        end
      end
    end
  endgenerate

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [4:0]        w_alu_op;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_result;

  assign w_op_a   = w_fwd[0];
  assign w_op_b   = EX_alusrc ? sext_imm(EX_immediate) : w_fwd[1];
  assign w_alu_op = EX_aluop ? EX_opcode : OP_ADD;
  assign w_shamt  = w_op_b[4:0];

  always_comb begin
    w_result = '0;
    case (w_alu_op)
      OP_ADD: w_result = w_op_a + w_op_b;
      OP_SUB: w_result = w_op_a - w_op_b;
      OP_AND: w_result = w_op_a & w_op_b;
      OP_OR:  w_result = w_op_a | w_op_b;
      OP_XOR: w_result = w_op_a ^ w_op_b;
      OP_NOT: w_result = ~w_op_a;
      OP_SLL: w_result = (w_shamt >= 5'(DATA_W)) ? '0 : (w_op_a << w_shamt);
      OP_SRL: w_result = (w_shamt >= 5'(DATA_W)) ? '0 : (w_op_a >> w_shamt);
      default: w_result = '0;  // MUL is produced by mul_iter19; undefined -> 0
    endcase
  end

  mem_ctrl_t         w_ex_ctrl;
  logic [REG_AW-1:0] w_dest;

  assign w_ex_ctrl = '{regwrite: EX_regwrite, memtoreg: EX_memtoreg,
                       memread:  EX_memread,  memwrite: EX_memwrite};
  assign w_dest    = EX_regdist ? EX_rd : EX_rt;

  // Multiply control.  While the multiplier is BUSY or DONE the same MUL
  // is still held in ID/EX, so a new start is only accepted when idle.
  logic              w_mul_req;
  logic              w_mul_start;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_product;

  assign w_mul_req   = EX_aluop && (EX_opcode == OP_MUL);
  assign w_mul_start = w_mul_req && !w_mul_busy && !w_mul_done && !ex_flush && !rst;
  assign ex_stall    = (w_mul_start || w_mul_busy) && !ex_flush && !rst;

  mul_iter19 u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_abort   (ex_flush),
    .i_a       (w_op_a),
    .i_b       (w_op_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  // Controls and destination of the multiply, captured at start so the
  // result is written back with them regardless of what ID/EX holds.
  mem_ctrl_t         r_mul_ctrl;
  logic [REG_AW-1:0] r_mul_wreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_ctrl     <= '0;
      r_mul_wreg     <= '0;
      MEM_regwrite   <= 1'b0;
      MEM_memtoreg   <= 1'b0;
      MEM_memread    <= 1'b0;
      MEM_memwrite   <= 1'b0;
      MEM_alu_result <= '0;
      MEM_store_data <= '0;
      MEM_wreg       <= '0;
      MEM_zero       <= 1'b0;
    end else begin
      if (w_mul_start) begin
        r_mul_ctrl <= w_ex_ctrl;
        r_mul_wreg <= w_dest;
      end

      if (ex_flush || (ex_stall && !w_mul_done)) begin
        // Bubble: controls cleared, data fields hold.
        MEM_regwrite <= 1'b0;
        MEM_memtoreg <= 1'b0;
        MEM_memread  <= 1'b0;
        MEM_memwrite <= 1'b0;
      end else if (w_mul_done) begin
        MEM_regwrite   <= r_mul_ctrl.regwrite;
        MEM_memtoreg   <= r_mul_ctrl.memtoreg;
        MEM_memread    <= r_mul_ctrl.memread;
        MEM_memwrite   <= r_mul_ctrl.memwrite;
        MEM_alu_result <= w_mul_product;
        MEM_wreg       <= r_mul_wreg;
        MEM_zero       <= (w_mul_product == '0);
      end else begin
        MEM_regwrite   <= w_ex_ctrl.regwrite;
        MEM_memtoreg   <= w_ex_ctrl.memtoreg;
        MEM_memread    <= w_ex_ctrl.memread;
        MEM_memwrite   <= w_ex_ctrl.memwrite;
        MEM_alu_result <= w_result;
        MEM_store_data <= w_fwd[1];
        MEM_wreg       <= w_dest;
        MEM_zero       <= (w_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
// Directed-vector bench for ex_stage: reset, ALU ops, forwarding,
// load address path, multiply timing, flush and reset aborts.
module tb_ex_stage;
  import cpu19_pkg::*;

  logic              clk;
  logic              rst;
  logic [4:0]        EX_opcode;
  logic              EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite;
  logic              EX_alusrc, EX_aluop, EX_regdist;
  logic [7:0]        EX_immediate;
  logic [2:0]        EX_rs, EX_rt, EX_rd;
  logic [18:0]       EX_rd1, EX_rd2;
  logic              WB_regwrite;
  logic [2:0]        WB_wreg;
  logic [18:0]       WB_wdata;
  logic              ex_flush;
  logic              ex_stall;
  logic              MEM_regwrite, MEM_memtoreg, MEM_memread, MEM_memwrite;
  logic [18:0]       MEM_alu_result, MEM_store_data;
  logic [2:0]        MEM_wreg;
  logic              MEM_zero;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .EX_opcode      (EX_opcode),
    .EX_regwrite    (EX_regwrite),
    .EX_memtoreg    (EX_memtoreg),
    .EX_memread     (EX_memread),
    .EX_memwrite    (EX_memwrite),
    .EX_alusrc      (EX_alusrc),
    .EX_aluop       (EX_aluop),
    .EX_regdist     (EX_regdist),
    .EX_immediate   (EX_immediate),
    .EX_rs          (EX_rs),
    .EX_rt          (EX_rt),
    .EX_rd          (EX_rd),
    .EX_rd1         (EX_rd1),
    .EX_rd2         (EX_rd2),
    .WB_regwrite    (WB_regwrite),
    .WB_wreg        (WB_wreg),
    .WB_wdata       (WB_wdata),
    .ex_flush       (ex_flush),
    .ex_stall       (ex_stall),
    .MEM_regwrite   (MEM_regwrite),
    .MEM_memtoreg   (MEM_memtoreg),
    .MEM_memread    (MEM_memread),
    .MEM_memwrite   (MEM_memwrite),
    .MEM_alu_result (MEM_alu_result),
    .MEM_store_data (MEM_store_data),
    .MEM_wreg       (MEM_wreg),
    .MEM_zero       (MEM_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // R-type defaults: decode opcode, register operand B, write rd.
  task automatic alu_op(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic [18:0] a, input logic [18:0] b);
    EX_opcode    = op;
    EX_aluop     = 1'b1;
    EX_alusrc    = 1'b0;
    EX_regdist   = 1'b1;
    EX_regwrite  = 1'b1;
    EX_memtoreg  = 1'b0;
    EX_memread   = 1'b0;
    EX_memwrite  = 1'b0;
    EX_immediate = 8'h00;
    EX_rs = rs; EX_rt = rt; EX_rd = rd;
    EX_rd1 = a; EX_rd2 = b;
  endtask

  task automatic run_alu(input string tag, input logic [4:0] op, input logic [18:0] a,
                         input logic [18:0] b, input logic [18:0] exp);
    alu_op(op, 3'd1, 3'd2, 3'd7, a, b);
    step();
    check(tag, MEM_alu_result, exp);
  endtask

  // Clock while ex_stall is high (bounded), counting stall cycles and any
  // MEM_regwrite seen meanwhile.  Leaves time at posedge+2.
  task automatic mul_wait(output int stall_cyc, output int pulses);
    stall_cyc = 0;
    pulses    = 0;
    #1;
    while (ex_stall && stall_cyc < 40) begin
      stall_cyc++;
      step();
      if (MEM_regwrite) pulses++;
      #1;
    end
  endtask

  task automatic run_mul(input string tag, input logic [18:0] a, input logic [18:0] b,
                         input logic [2:0] rd, input logic [18:0] exp);
    int sc;
    int pc;
    alu_op(OP_MUL, 3'd1, 3'd2, rd, a, b);
    mul_wait(sc, pc);
    check({tag, "_stall_cycles"}, sc, 20);
    check({tag, "_bubbles"}, pc, 0);
    step();
    check({tag, "_result"}, MEM_alu_result, exp);
    check({tag, "_regwrite"}, MEM_regwrite, 1);
    check({tag, "_wreg"}, MEM_wreg, rd);
    EX_opcode = OP_ADD;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int pc;
    WB_regwrite = 1'b0; WB_wreg = 3'd0; WB_wdata = '0;
    ex_flush = 1'b0;
    // Reset with a MUL presented: stall must stay low, MEM cleared.
    alu_op(OP_MUL, 3'd1, 3'd2, 3'd4, 19'd3, 19'd3);
    rst = 1'b1;
    step(); step();
    check("rst_stall", ex_stall, 0);
    check("rst_regwrite", MEM_regwrite, 0);
    check("rst_memread", MEM_memread, 0);
    check("rst_result", MEM_alu_result, 0);
    check("rst_wreg", MEM_wreg, 0);
    check("rst_zero", MEM_zero, 0);

    alu_op(OP_ADD, 3'd1, 3'd2, 3'd4, 19'h00010, 19'h00005);
    rst = 1'b0;
    step();
    check("add_result", MEM_alu_result, 19'h00015);
    check("add_zero", MEM_zero, 0);
    check("add_regwrite", MEM_regwrite, 1);
    check("add_wreg", MEM_wreg, 4);
    check("add_store", MEM_store_data, 19'h00005);

    alu_op(OP_SUB, 3'd1, 3'd2, 3'd5, 19'h1A5A5, 19'h1A5A5);
    step();
    check("sub_result", MEM_alu_result, 0);
    check("sub_zero", MEM_zero, 1);

    // Producer writes r3 = 0x100.
    alu_op(OP_ADD, 3'd1, 3'd2, 3'd3, 19'h00100, 19'h0);
    EX_alusrc = 1'b1;
    step();
    check("prod_r3", MEM_alu_result, 19'h00100);
    // r3 + (-1) with stale rd1: MEM forward.
    alu_op(OP_ADD, 3'd3, 3'd2, 3'd6, 19'h0, 19'h0);
    EX_alusrc = 1'b1; EX_immediate = 8'hFF;
    step();
    check("fwd_mem", MEM_alu_result, 19'h000FF);
    // Same through WB only.
    alu_op(OP_ADD, 3'd3, 3'd2, 3'd7, 19'h0, 19'h0);
    EX_alusrc = 1'b1; EX_immediate = 8'hFF;
    WB_regwrite = 1'b1; WB_wreg = 3'd3; WB_wdata = 19'h00100;
    step();
    check("fwd_wb", MEM_alu_result, 19'h000FF);
    // MEM (r7 = 0xFF) beats WB (r7 = 0x12345).
    alu_op(OP_ADD, 3'd7, 3'd0, 3'd2, 19'h0, 19'h00001);
    WB_wreg = 3'd7; WB_wdata = 19'h12345;
    step();
    check("fwd_prio", MEM_alu_result, 19'h00100);
    WB_regwrite = 1'b0;
    // rt path forward: r2 = 0x100 in MEM.
    alu_op(OP_SUB, 3'd1, 3'd2, 3'd1, 19'h00150, 19'h0);
    step();
    check("fwd_rt", MEM_alu_result, 19'h00050);

    // Load address: aluop=0 forces ADD, destination is rt.
    alu_op(5'b10000, 3'd0, 3'd3, 3'd4, 19'h00020, 19'h0);
    EX_aluop = 1'b0; EX_alusrc = 1'b1; EX_immediate = 8'h04;
    EX_memread = 1'b1; EX_memtoreg = 1'b1; EX_regdist = 1'b0;
    step();
    check("ld_addr", MEM_alu_result, 19'h00024);
    check("ld_memread", MEM_memread, 1);
    check("ld_memtoreg", MEM_memtoreg, 1);
    check("ld_wreg", MEM_wreg, 3);
    // r3 is a pending load in MEM: must not be forwarded.
    alu_op(OP_ADD, 3'd3, 3'd0, 3'd4, 19'h00007, 19'h00001);
    step();
    check("no_fwd_load", MEM_alu_result, 19'h00008);

    run_alu("and", OP_AND, 19'h5A5A5, 19'h0F0F3, 19'h0A0A1);
    run_alu("or",  OP_OR,  19'h5A5A5, 19'h0F0F3, 19'h5F5F7);
    run_alu("xor", OP_XOR, 19'h5A5A5, 19'h0F0F3, 19'h55556);
    run_alu("not", OP_NOT, 19'h5A5A5, 19'h0F0F3, 19'h25A5A);
    run_alu("sll_4",  OP_SLL, 19'h00003, 19'd4,  19'h00030);
    run_alu("sll_18", OP_SLL, 19'h00001, 19'd18, 19'h40000);
    run_alu("sll_19", OP_SLL, 19'h00001, 19'd19, 19'h00000);
    run_alu("srl_18", OP_SRL, 19'h40000, 19'd18, 19'h00001);
    run_alu("srl_19", OP_SRL, 19'h7FFFF, 19'd19, 19'h00000);
    run_alu("srl_b32", OP_SRL, 19'h7FFFF, 19'd32, 19'h7FFFF);
    run_alu("sub_wrap", OP_SUB, 19'h00000, 19'h00001, 19'h7FFFF);
    run_alu("add_wrap", OP_ADD, 19'h7FFFF, 19'h00001, 19'h00000);
    check("add_wrap_zero", MEM_zero, 1);
    run_alu("undef_03", 5'b00011, 19'h00005, 19'h00003, 19'h00000);
    run_alu("undef_1f", 5'b11111, 19'h00005, 19'h00003, 19'h00000);

    run_mul("mul_300x5", 19'd300, 19'd5, 3'd6, 19'd1500);
    run_mul("mul_max_x2", 19'h7FFFF, 19'd2, 3'd5, 19'h7FFFE);

    // Single-cycle flush.
    alu_op(OP_ADD, 3'd1, 3'd2, 3'd3, 19'd1, 19'd1);
    ex_flush = 1'b1;
    step();
    ex_flush = 1'b0;
    check("flush_alu_regwrite", MEM_regwrite, 0);

    // Flush at BUSY cycle 7.
    alu_op(OP_MUL, 3'd1, 3'd2, 3'd5, 19'd300, 19'd5);
    pc = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (MEM_regwrite) pc++;
    end
    check("flush_busy_stall_before", ex_stall, 1);
    ex_flush = 1'b1;
    #1;
    check("flush_busy_stall_same", ex_stall, 0);
    step();
    ex_flush = 1'b0;
    check("flush_busy_regwrite", MEM_regwrite, 0);
    check("flush_busy_bubbles", pc, 0);
    alu_op(OP_ADD, 3'd1, 3'd2, 3'd3, 19'd2, 19'd3);
    #1;
    check("flush_busy_idle", ex_stall, 0);
    step();
    check("flush_busy_add", MEM_alu_result, 19'd5);
    check("flush_busy_add_rw", MEM_regwrite, 1);

    // Flush in DONE beats the multiply result.
    alu_op(OP_MUL, 3'd1, 3'd2, 3'd5, 19'd7, 19'd9);
    mul_wait(sc, pc);
    check("flush_done_stall_cycles", sc, 20);
    ex_flush = 1'b1;
    step();
    ex_flush = 1'b0;
    check("flush_done_regwrite", MEM_regwrite, 0);
    alu_op(OP_ADD, 3'd1, 3'd2, 3'd3, 19'd4, 19'd4);
    #1;
    check("flush_done_idle", ex_stall, 0);
    step();
    check("flush_done_add", MEM_alu_result, 19'd8);

    // Reset at BUSY cycle 7.
    alu_op(OP_MUL, 3'd1, 3'd2, 3'd5, 19'd300, 19'd5);
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    #1;
    check("rst_busy_stall_same", ex_stall, 0);
    step();
    rst = 1'b0;
    check("rst_busy_regwrite", MEM_regwrite, 0);
    alu_op(OP_ADD, 3'd1, 3'd2, 3'd3, 19'h00010, 19'h00020);
    #1;
    check("rst_busy_idle", ex_stall, 0);
    step();
    check("rst_busy_add", MEM_alu_result, 19'h00030);
    check("rst_busy_add_rw", MEM_regwrite, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 19-bit pipelined CPU; sits directly downstream of the ID/EX pipeline register and consumes its EX_* outputs.
- Forwards operands from MEM and WB, then performs ALU operations and an iterative 19-cycle multiply.
- Owns the EX/MEM pipeline register, drives the MEM_* outputs, and raises a stall to upstream stages while a multiply runs.

Parameters:
- DATA_W, 19, datapath width
- REG_AW, 3, register index width (8 GPRs, no hardwired zero)
- IMM_W, 8, immediate width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- EX_opcode  in  5  instruction opcode
- EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite  in  1 each  control bits, passed to MEM
- EX_alusrc  in  1  1 = operand B is the sign-extended immediate
- EX_aluop  in  1  0 = force ADD (load/store address); 1 = decode opcode
- EX_regdist  in  1  1 = destination is rd, 0 = rt
- EX_immediate  in  IMM_W  immediate
- EX_rs, EX_rt, EX_rd  in  REG_AW  register indices
- EX_rd1, EX_rd2  in  DATA_W  register file read data
- WB_regwrite  in  1  WB stage writes a register
- WB_wreg  in  REG_AW  WB destination index
- WB_wdata  in  DATA_W  WB write data
- ex_flush  in  1  kill the instruction in EX (branch redirect)
- ex_stall  out  1  hold IF/ID and ID/EX
- MEM_regwrite, MEM_memtoreg, MEM_memread, MEM_memwrite  out  1 each  registered control bits
- MEM_alu_result  out  DATA_W  registered result or address
- MEM_store_data  out  DATA_W  registered forwarded rd2
- MEM_wreg  out  REG_AW  registered destination index
- MEM_zero  out  1  registered (result == 0)

Behaviour:
- Reset: all MEM_* outputs are 0, FSM goes to IDLE, ex_stall is 0. Reset mid-multiply aborts the multiply.
- Forwarding, per operand, for the rs path (rd1) and the rt path (rd2):
  - Priority 1, MEM: MEM_regwrite & !MEM_memtoreg & MEM_wreg == index → MEM_alu_result.
  - Priority 2, WB: WB_regwrite & WB_wreg == index → WB_wdata.
  - Otherwise the register file value is used.
  - Load-use hazards are the hazard unit's job; this block never forwards from a MEM-stage load.
- Operands: A = forwarded rd1. B = EX_alusrc ? sign-extended EX_immediate : forwarded rd2.
- Opcodes (when aluop = 1):
  - ADD 00000, SUB 00001, MUL 00010, AND 00100, OR 00101, XOR 00110, NOT 00111 (~A)
  - SLL 01000, SRL 01001 (shift amount is B[4:0]; shifts of 19 or more give 0)
  - Undefined opcodes give 0.
  - All arithmetic is modulo 2^19, with no carry or overflow flag.
- Single-cycle operations: on each edge with no stall and no flush, MEM_* ← control bits, result, forwarded rd2, (regdist ? rd : rt), and (result == 0).
- Multiply FSM, states IDLE → BUSY → DONE → IDLE:
  - IDLE, multiply presented (aluop = 1, opcode MUL): ex_stall = 1 combinationally. At the edge, capture the forwarded A, B and destination, load counter = 0, go to BUSY, and write a bubble to MEM.
  - BUSY: shift-add one multiplier bit per cycle; ex_stall = 1; MEM gets a bubble each edge. After 19 cycles (counter = 18) go to DONE.
  - DONE: ex_stall = 0; the held ID/EX multiply is consumed without restarting. At the edge, MEM ← low 19 bits of the product with the captured controls; go to IDLE.
  - Timing: stall is high for 20 cycles, and the result lands 21 edges after presentation.
- Flush:
  - ex_flush = 1 makes the next MEM_* control bits (regwrite, memtoreg, memread, memwrite) 0. Data fields are don't-care.
  - In BUSY or DONE, flush aborts to IDLE and ex_stall drops in the same cycle.
  - Flush takes priority over a multiply result.
- Bubble: all four MEM control bits 0; data fields hold their previous values.

Decomposition:
- Package cpu19_pkg: DATA_W/REG_AW/IMM_W constants, opcode localparams (OP_ADD through OP_SRL), FSM state encoding.
- One natural sub-module: mul_iter19, the iterative shift-add multiplier (start, operands, busy, done, product).
- Forwarding mux and ALU stay inline.

Test Plan:
- ADD r1,r2 with rd1 = 0x00010, rd2 = 0x00005, no forwarding → next edge MEM_alu_result = 0x00015, MEM_zero = 0.
- SUB with rd1 = rd2 = 0x1A5A5 → MEM_alu_result = 0, MEM_zero = 1.
- Back-to-back dependency: the previous op writes r3 = 0x00100, the next op ADDs r3 + imm 8'hFF (sign-extended to −1) with stale rd1 = 0 → MEM forward used, result 0x000FF. Repeat with WB_wdata as the only match → WB forward used.
- Load (aluop = 0, alusrc = 1, memread = 1), rd1 = 0x00020, imm = 8'h04 → MEM_alu_result = 0x00024, MEM_memread = 1, MEM_wreg = rt.
- MUL 300 × 5 → ex_stall high for exactly 20 cycles, MEM control bits 0 meanwhile, then MEM_alu_result = 1500. MUL 0x7FFFF × 2 → 0x7FFFE.
- Flush or rst asserted at BUSY cycle 7 → ex_stall low the same/next cycle, FSM in IDLE, no MEM_regwrite pulse; a following ADD completes normally.
